// File: rtl/ysyx_040066_trap_pkg.sv
// Shared definitions for the trap sequencer: FSM encoding, trap cause codes, CSR bit positions.
// No logic; constants only.
// Not applicable (no flow control).
package ysyx_040066_trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_RET   = 2'd2,
        ST_REDIR = 2'd3
    } trap_state_t;

    localparam logic [63:0] CAUSE_TIMER       = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CAUSE_ECALL_M     = 64'd11;
    localparam logic [63:0] CAUSE_ILLEGAL     = 64'd2;
    localparam logic [63:0] CAUSE_BREAK       = 64'd3;
    localparam logic [63:0] CAUSE_LD_MISALIGN = 64'd4;
    localparam logic [63:0] CAUSE_ST_MISALIGN = 64'd6;

    localparam int MSTATUS_MIE = 3;
    localparam int MIE_MTIE    = 7;

endpackage

// File: rtl/ysyx_040066_sync2.sv
// Generic two-flop synchronizer for a single level signal from another clock domain.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none.
module ysyx_040066_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ysyx_040066_trap_ctrl.sv
// Trap sequencer in front of the CSR file: picks interrupt / exception / mret at commit.
// Latency: decision at commit, CSR pulse next cycle (later while csr_wen blocks it), then REDIR until redir_ack.
// Backpressure: cmt_stall holds commit off whenever a trap or return is in flight.
module ysyx_040066_trap_ctrl
    import ysyx_040066_trap_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] TIMER_CAUSE = XLEN'(CAUSE_TIMER)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmt_valid,
    input  logic [XLEN-1:0] cmt_pc,
    input  logic            cmt_exc,
    input  logic [XLEN-1:0] cmt_cause,
    input  logic [XLEN-1:0] cmt_tval,
    input  logic            cmt_mret,
    input  logic            csr_wen,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic            timer_irq,
    input  logic            redir_ack,
    output logic            cmt_kill,
    output logic            cmt_stall,
    output logic            flush,
    output logic            raise_intr,
    output logic [XLEN-1:0] NO,
    output logic [XLEN-1:0] tval,
    output logic [XLEN-1:0] pc,
    output logic            ret,
    output logic            clear_mip
);

    trap_state_t state, state_nxt;
    logic        irq_s, irq_s_d, irq_take;
    logic        ack_seen;
    logic        unused_bits;

    ysyx_040066_sync2 u_sync_irq (
        .clk (clk),
        .rst (rst),
        .d   (timer_irq),
        .q   (irq_s)
    );

    assign irq_take    = irq_s & mstatus[MSTATUS_MIE] & mie[MIE_MTIE];
    assign cmt_stall   = (state != ST_IDLE);
    assign unused_bits = ^{mstatus, mie, cmt_cause[XLEN-1]};

    always_comb begin
        state_nxt  = state;
        cmt_kill   = 1'b0;
        flush      = 1'b0;
        raise_intr = 1'b0;
        ret        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmt_valid) begin
                    if (irq_take || cmt_exc) begin
                        cmt_kill  = 1'b1;
                        flush     = 1'b1;
                        state_nxt = ST_TRAP;
                    end else if (cmt_mret) begin
                        flush     = 1'b1;
                        state_nxt = ST_RET;
                    end
                end
            end
            ST_TRAP: begin
                flush = 1'b1;
                // The CSR file would drop a trap that lands on the same cycle as a CSR write.
                if (!csr_wen) begin
                    raise_intr = 1'b1;
                    state_nxt  = ST_REDIR;
                end
            end
            ST_RET: begin
                flush     = 1'b1;
                ret       = 1'b1;
                state_nxt = ST_REDIR;
            end
            ST_REDIR: begin
                flush = 1'b1;
                if (redir_ack || ack_seen) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ack_seen  <= 1'b0;
            irq_s_d   <= 1'b0;
            clear_mip <= 1'b0;
            NO        <= '0;
            tval      <= '0;
            pc        <= '0;
        end else begin
            state     <= state_nxt;
            // An ack arriving with the CSR pulse lets REDIR finish after a single cycle.
            ack_seen  <= (raise_intr | ret) & redir_ack;
            irq_s_d   <= irq_s;
            clear_mip <= irq_s_d & ~irq_s;
            if (state == ST_IDLE && cmt_valid) begin
                if (irq_take) begin
                    NO   <= TIMER_CAUSE;
                    tval <= '0;
                    pc   <= cmt_pc;
                end else if (cmt_exc) begin
                    NO   <= {1'b0, cmt_cause[XLEN-2:0]};
                    tval <= cmt_tval;
                    pc   <= cmt_pc;
                end
            end
        end
    end

endmodule
